// File: rtl/lut_table_writer.sv
// lut_table_writer: byte-wise loader for a 1-bit lookup table.
// Bytes go to a shadow table; an XOR checksum byte closes each load. The
// shadow is copied to the active table only when the checksum matches.
// Lookups always read the active table with a fixed one-cycle latency.
module lut_table_writer #(
  parameter int unsigned IN_W   = 6,
  parameter int unsigned NBYTES = (2 ** IN_W) / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic [7:0]      cfg_data,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            cfg_err,
  input  logic            lut_valid_in,
  input  logic [IN_W-1:0] lut_in,
  output logic            lut_out,
  output logic            lut_valid_out
);

  localparam int unsigned DEPTH = 2 ** IN_W;
  localparam int unsigned CNT_W = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       csum;
  logic [DEPTH-1:0] shadow;
  logic [DEPTH-1:0] active;
  logic             xfer_c;

  // A byte moves only when both sides agree on the same cycle.
  assign xfer_c = cfg_valid & cfg_ready;

  // Load sequencer: shadow fill, running checksum, commit or reject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      csum      <= '0;
      shadow    <= '0;
      active    <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            cnt       <= '0;
            csum      <= '0;
            cfg_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            // Restart wins over a coincident byte, which is dropped.
            cnt  <= '0;
            csum <= '0;
          end else if (xfer_c) begin
            for (int k = 0; k < int'(NBYTES); k++) begin
              if (cnt == CNT_W'(k)) shadow[k*8 +: 8] <= cfg_data;
            end
            csum <= csum ^ cfg_data;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(NBYTES - 1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
            csum  <= '0;
          end else if (xfer_c) begin
            if (cfg_data == csum) begin
              active   <= shadow;
              cfg_done <= 1'b1;
            end else begin
              cfg_err  <= 1'b1;
            end
            state     <= IDLE;
            cfg_ready <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // Lookup pipe: reads the pre-update active table on a commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_out       <= 1'b0;
      lut_valid_out <= 1'b0;
    end else begin
      lut_valid_out <= lut_valid_in;
      if (lut_valid_in) lut_out <= active[lut_in];
    end
  end

endmodule

// File: tb/tb_lut_table_writer.sv
// Scoreboard bench for lut_table_writer: stimulus pushes expectations,
// a negedge monitor pops them whenever the DUT presents a result.
module tb_lut_table_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready, cfg_done, cfg_err;
  logic       lut_valid_in = 1'b0;
  logic [5:0] lut_in = 6'h00;
  logic       lut_out, lut_valid_out;

  int nvec = 0;
  int nmis = 0;

  logic [63:0] model = '0;
  logic        lut_q [$];
  logic [1:0]  cfg_q [$];   // {done, err}
  logic        last_exp = 1'b0;

  lut_table_writer #(.IN_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .lut_valid_in(lut_valid_in), .lut_in(lut_in),
    .lut_out(lut_out), .lut_valid_out(lut_valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented lookup result and config pulse.
  always @(negedge clk) begin
    logic       e;
    logic [1:0] ce;
    if (!rst_n) begin
      last_exp = 1'b0;
    end else begin
      if (lut_valid_out) begin
        if (lut_q.size() == 0) begin
          check("unexpected_lut_valid_out", 8'(lut_valid_out), 8'h0);
        end else begin
          e = lut_q.pop_front();
          check("lut_out", 8'(lut_out), 8'(e));
          last_exp = e;
        end
      end else begin
        check("lut_out_hold", 8'(lut_out), 8'(last_exp));
      end
      if (cfg_done || cfg_err) begin
        if (cfg_q.size() == 0) begin
          check("unexpected_done_err", {6'h0, cfg_done, cfg_err}, 8'h0);
        end else begin
          ce = cfg_q.pop_front();
          check("done_err", {6'h0, cfg_done, cfg_err}, {6'h0, ce});
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [5:0] a);
    lut_valid_in = 1'b1;
    lut_in       = a;
    lut_q.push_back(model[a]);
    step();
    lut_valid_in = 1'b0;
  endtask

  task automatic start(input bit with_byte);
    cfg_start = 1'b1;
    if (with_byte) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'hAA;
    end
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // Offer one byte after some idle cycles; optionally a lookup on the transfer cycle.
  task automatic send(input logic [7:0] d, input int stall, input bit look, input logic [5:0] a);
    int n = 0;
    cfg_valid = 1'b0;
    repeat (stall) begin
      cfg_data = 8'($urandom);
      step();
    end
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 20) begin
      step();
      n++;
    end
    if (!cfg_ready) begin
      check("cfg_ready_timeout", 8'(cfg_ready), 8'h1);
      cfg_valid = 1'b0;
      return;
    end
    if (look) begin
      lut_valid_in = 1'b1;
      lut_in       = a;
      lut_q.push_back(model[a]);
    end
    step();
    cfg_valid    = 1'b0;
    lut_valid_in = 1'b0;
  endtask

  // Full load: 8 table bytes then checksum; caddr >= 0 adds commit-cycle lookups.
  task automatic load(input logic [7:0] b [8], input logic [7:0] cs, input int stall_max, input int caddr);
    logic [7:0] x = 8'h00;
    logic       ok;
    for (int k = 0; k < 8; k++) x ^= b[k];
    ok = (cs == x);
    start(1'b0);
    for (int k = 0; k < 8; k++) send(b[k], $urandom_range(0, stall_max), 1'b0, 6'h0);
    cfg_q.push_back(ok ? 2'b10 : 2'b01);
    send(cs, $urandom_range(0, stall_max), caddr >= 0, 6'(caddr));
    if (ok) for (int k = 0; k < 8; k++) model[k*8 +: 8] = b[k];
    if (caddr >= 0) lookup(6'(caddr));
    repeat (2) step();
  endtask

  logic [7:0] pat [8];
  logic [7:0] ones [8];
  logic [7:0] walk [8];

  initial begin
    pat  = '{8'h0C, 8'h3F, 8'h0F, 8'h3F, 8'h00, 8'h30, 8'h00, 8'h33};
    ones = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    #12;
    check("reset_outputs", {3'b0, cfg_ready, cfg_done, cfg_err, lut_out, lut_valid_out}, 8'h00);
    rst_n = 1'b1;
    step();
    check("post_release_outputs", {3'b0, cfg_ready, cfg_done, cfg_err, lut_out, lut_valid_out}, 8'h00);

    // Empty table after reset.
    lookup(6'h3F);
    step();

    // Writes in IDLE are ignored and never accepted.
    cfg_valid = 1'b1;
    cfg_data  = 8'h55;
    repeat (3) begin
      step();
      check("idle_ready_low", 8'(cfg_ready), 8'h0);
    end
    cfg_valid = 1'b0;

    // Good load; the XOR of the pattern bytes is 0x00.
    load(pat, 8'h00, 0, -1);
    lookup(6'h02); lookup(6'h00); lookup(6'h3F); lookup(6'h03); lookup(6'h08);
    step();

    // Bad checksum: error pulse, table unchanged.
    load(pat, 8'h10, 0, -1);
    lookup(6'h02); lookup(6'h00); lookup(6'h3F);
    step();

    // Abort after 4 bytes with a coincident byte dropped, then all-ones load.
    start(1'b0);
    for (int k = 0; k < 4; k++) send(8'h11, 0, 1'b0, 6'h0);
    start(1'b1);
    step();
    load(ones, 8'h00, 0, -1);
    for (int a = 0; a < 64; a++) lookup(6'(a));
    step();

    // Bad load over an all-ones table keeps it all ones.
    load(pat, 8'h10, 1, -1);
    lookup(6'h00); lookup(6'h3F);
    step();

    // Stalled load; lookup on the commit cycle sees old, next cycle sees new.
    load(walk, 8'hFF, 2, 8);
    lookup(6'h09); lookup(6'h00); lookup(6'h01); lookup(6'h3F); lookup(6'h3E);
    step();

    // Reset mid-load with a lookup result on the outputs.
    start(1'b0);
    for (int k = 0; k < 3; k++) send(8'h77, 0, 1'b0, 6'h0);
    lut_valid_in = 1'b1;
    lut_in       = 6'h00;
    @(posedge clk);
    #3;
    lut_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {3'b0, cfg_ready, cfg_done, cfg_err, lut_out, lut_valid_out}, 8'h00);
    model = '0;
    step();
    rst_n = 1'b1;
    step();
    check("release_no_pulse", {6'h0, cfg_done, cfg_err}, 8'h00);
    for (int a = 0; a < 64; a++) lookup(6'(a));
    repeat (3) step();

    check("pending_lut", 8'(lut_q.size()), 8'h0);
    check("pending_cfg", 8'(cfg_q.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
